// File: rtl/fft_io_pkg.sv
// ============================================================================
// Module   : fft_io_pkg
// Brief    : Shared state encoding and address/slice helpers for fft_io_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fft_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam int c_max_addr_w = 16;

    // Reverses the low 'width' bits of val; bits above width come back zero.
    function automatic logic [c_max_addr_w-1:0] bit_rev(input logic [c_max_addr_w-1:0] val,
                                                        input int width);
        logic [c_max_addr_w-1:0] res;
        res = '0;
        for (int i = 0; i < c_max_addr_w; i++) begin
            if (i < width) begin
                res[width-1-i] = val[i];
            end
        end
        return res;
    endfunction

    function automatic int lane_off(input int lane, input int word_size);
        return lane * 2 * word_size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_io_skid.sv
// ============================================================================
// Module   : fft_io_skid
// Brief    : Two-entry ready/valid buffer absorbing the one-cycle read latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_io_skid #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = in_valid & (r_count != 2'd2);
    assign w_pop     = out_valid & out_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head ? r_slot1 : r_slot0;
    assign level     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_tail) r_slot1 <= in_data;
                else        r_slot0 <= in_data;
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_io_ctrl.sv
// ============================================================================
// Module   : fft_io_ctrl
// Brief    : Frame load / FFT launch / result unload controller with backpressure.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_io_ctrl
    import fft_io_pkg::*;
#(
    parameter int N         = 32,
    parameter int WORD_SIZE = 16,
    parameter int LANES     = 2,
    parameter int ADDR_W    = $clog2(N)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*2*WORD_SIZE-1:0]   in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*2*WORD_SIZE-1:0]   out_data,
    output logic                           out_last,
    input  logic                           bitrev_out,
    output logic                           mem_wr_en,
    output logic [LANES*ADDR_W-1:0]        mem_wr_addr,
    output logic [LANES*2*WORD_SIZE-1:0]   mem_wr_data,
    output logic                           mem_rd_en,
    output logic [LANES*ADDR_W-1:0]        mem_rd_addr,
    input  logic [LANES*2*WORD_SIZE-1:0]   mem_rd_data,
    output logic                           fft_start,
    input  logic                           fft_done,
    output logic                           busy,
    output logic                           frame_err
);

    localparam int c_sample_w = 2 * WORD_SIZE;
    localparam int c_data_w   = LANES * c_sample_w;
    localparam int c_beats    = N / LANES;
    localparam int c_cnt_w    = $clog2(c_beats);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic [c_cnt_w-1:0]   r_rd_cnt;
    logic                 r_bitrev;
    logic                 r_accept_ok;
    logic                 r_fft_start;
    logic                 r_frame_err;
    logic                 r_rd_pend;
    logic                 r_pend_last;

    logic                 w_in_fire;
    logic                 w_rd_fire;
    logic                 w_skid_ready;
    logic                 w_skid_pop;
    logic [1:0]           w_level;
    logic [c_data_w:0]    w_skid_out;

    assign in_ready     = r_accept_ok & en;
    assign w_in_fire    = in_valid & in_ready;
    assign w_skid_ready = out_ready & en;
    assign w_skid_pop   = out_valid & w_skid_ready;

    // Issue a read only if the beat it returns next cycle is guaranteed a slot.
    assign w_rd_fire = en & (r_state == ST_UNLOAD) &
                       (({1'b0, w_level} + {2'b00, r_rd_pend}) <= (3'd1 + {2'b00, w_skid_pop}));

    assign mem_wr_en = w_in_fire;
    assign mem_rd_en = w_rd_fire;
    assign fft_start = r_fft_start;
    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;
    assign out_data  = w_skid_out[c_data_w-1:0];
    assign out_last  = w_skid_out[c_data_w];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int c_off = lane_off(l, WORD_SIZE);
        logic [ADDR_W-1:0] w_wr_k;
        logic [ADDR_W-1:0] w_rd_k;
        logic [ADDR_W-1:0] w_rd_a;

        assign w_wr_k = ADDR_W'(int'(r_beat_cnt) * LANES + l);
        assign w_rd_k = ADDR_W'(int'(r_rd_cnt) * LANES + l);
        assign w_rd_a = r_bitrev ? ADDR_W'(bit_rev(c_max_addr_w'(w_rd_k), ADDR_W)) : w_rd_k;

        assign mem_wr_addr[l*ADDR_W +: ADDR_W]     = w_in_fire ? w_wr_k : '0;
        assign mem_rd_addr[l*ADDR_W +: ADDR_W]     = w_rd_fire ? w_rd_a : '0;
        assign mem_wr_data[c_off +: c_sample_w]    = w_in_fire ? in_data[c_off +: c_sample_w] : '0;
    end

    fft_io_skid #(
        .WIDTH (c_data_w + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_rd_pend),
        .in_data   ({r_pend_last, mem_rd_data}),
        .out_valid (out_valid),
        .out_ready (w_skid_ready),
        .out_data  (w_skid_out),
        .level     (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_rd_cnt    <= '0;
            r_bitrev    <= 1'b0;
            r_accept_ok <= 1'b0;
            r_fft_start <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_fft_start <= 1'b0;
            r_rd_pend   <= w_rd_fire;
            r_pend_last <= w_rd_fire & (r_rd_cnt == c_last_beat);
            if (en) begin
                case (r_state)
                    ST_IDLE: begin
                        r_accept_ok <= 1'b1;
                        if (w_in_fire) begin
                            r_bitrev   <= bitrev_out;
                            r_beat_cnt <= c_cnt_w'(1);
                            r_state    <= ST_LOAD;
                            if (in_last) r_frame_err <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (w_in_fire) begin
                            if (in_last != (r_beat_cnt == c_last_beat)) r_frame_err <= 1'b1;
                            if (r_beat_cnt == c_last_beat) begin
                                r_beat_cnt  <= '0;
                                r_accept_ok <= 1'b0;
                                r_fft_start <= 1'b1;
                                r_state     <= ST_RUN;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (fft_done) begin
                            r_rd_cnt <= '0;
                            r_state  <= ST_UNLOAD;
                        end
                    end
                    ST_UNLOAD: begin
                        if (w_rd_fire) begin
                            if (r_rd_cnt == c_last_beat) begin
                                r_rd_cnt <= '0;
                                r_state  <= ST_DRAIN;
                            end else begin
                                r_rd_cnt <= r_rd_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if ((w_level == 2'd0) && !r_rd_pend) begin
                            r_accept_ok <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fft_io_ctrl.md
Name: fft_io_ctrl

Overview:
- Frame-level I/O controller between the streaming outside world and the FFT working memory.
- Owns a full frame handshake: load N samples, start the FFT, wait for done, then unload N results.
- Successor to the fixed two-sample I/O block, with these additions:
  - LANES samples per beat.
  - Ready/valid backpressure on both sides.
  - Selectable natural or bit-reversed output order.
  - Frame-length checking via last flags.

Parameters:
- N, 32, FFT points per frame; power of 2, at least 2*LANES.
- WORD_SIZE, 16, bits per real/imag component; a sample is 2*WORD_SIZE bits.
- LANES, 2, samples per beat; power of 2, divides N.
- ADDR_W, $clog2(N), memory address width per lane.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; when low the FSM holds its state and no handshake completes
- in_valid  in  1  outside world has a beat
- in_ready  out  1  controller accepts a beat
- in_data  in  LANES*2*WORD_SIZE  lane l occupies bits [l*2*WORD_SIZE +: 2*WORD_SIZE]
- in_last  in  1  marks the final beat of an input frame
- out_valid  out  1  result beat available
- out_ready  in  1  receiver accepts a beat
- out_data  out  LANES*2*WORD_SIZE  result beat, same lane packing as in_data
- out_last  out  1  final result beat
- bitrev_out  in  1  output order select; sampled at the IDLE->LOAD transition
- mem_wr_en  out  1  write strobe to FFT memory
- mem_wr_addr  out  LANES*ADDR_W  per-lane write addresses
- mem_wr_data  out  LANES*2*WORD_SIZE  per-lane write data
- mem_rd_en  out  1  read strobe; data returns one cycle later
- mem_rd_addr  out  LANES*ADDR_W  per-lane read addresses
- mem_rd_data  in  LANES*2*WORD_SIZE  read data
- fft_start  out  1  one-cycle pulse launching the FFT
- fft_done  in  1  one-cycle pulse, FFT finished
- busy  out  1  high in every state except IDLE
- frame_err  out  1  sticky length error; cleared only by reset

Behaviour:
- Reset (asynchronous): state IDLE, all counters 0, all outputs 0.
- States: IDLE, LOAD, RUN, UNLOAD, DRAIN.

IDLE:
- in_ready=1 while en is high.
- The first accepted beat is written and the state moves to LOAD.
- bitrev_out is latched on that same transition.

LOAD:
- Beat accepted on in_valid & in_ready & en.
- Same cycle: mem_wr_en=1, and lane l gets address beat_cnt*LANES+l. Combinational write path, zero latency.
- beat_cnt counts 0..N/LANES-1.
- On the final beat (beat_cnt=N/LANES-1):
  - in_ready drops the next cycle.
  - fft_start pulses for 1 cycle, the cycle after the final write.
  - State moves to RUN.
- If in_last arrives on any other beat, or is absent on the final beat, set frame_err. The frame is still processed at full length.

RUN:
- in_ready=0, out_valid=0, no memory strobes.
- fft_done moves the state to UNLOAD.
- fft_done in any other state is ignored.

UNLOAD:
- Result index k = rd_cnt*LANES+l.
- Lane address = k in natural order, or bitrev(k) over ADDR_W bits when the latched mode is set.
- Read issued (mem_rd_en=1) whenever the skid buffer can take a beat. Data is captured into the skid one cycle later.
- Sustains 1 beat/cycle while out_ready=1.
- Backpressure never loses or duplicates a beat; out_data is held stable while out_valid & !out_ready.
- After the last read is issued, the state moves to DRAIN.

DRAIN:
- Wait until the skid buffer is empty.
- out_last=1 on the beat with k-base N-LANES.
- State returns to IDLE, and in_ready rises the next cycle.

Boundary rules:
- en low mid-frame freezes the counters and the FSM. An output beat that is already valid stays valid.
- Reset in any state aborts immediately. Memory contents are don't-care, and no fft_start is issued.
- in_valid in RUN, UNLOAD or DRAIN is ignored (in_ready=0).
- Minimum latency from the first accepted beat to the first output beat = N/LANES + RUN time + 2 cycles.

Decomposition:
- Package fft_io_pkg holds:
  - the state encoding;
  - a function computing bitrev over ADDR_W bits;
  - a function computing the lane slice offset.
- Sub-module fft_io_skid: a 2-entry ready/valid skid buffer, parameter WIDTH, carrying out_data plus out_last. It absorbs the 1-cycle memory read latency.

Test Plan:
- N=32, LANES=2, continuous input 0..31 with in_last on beat 15:
  - mem_wr_addr pairs (0,1)..(30,31);
  - fft_start one cycle after beat 15;
  - frame_err=0.
- Memory model returning the address as data, fft_done pulse, bitrev_out=0, out_ready=1:
  - out_data pairs (0,1),(2,3)..(30,31) on 16 consecutive cycles;
  - out_last on the 16th beat.
- Same as above with bitrev_out=1:
  - first beat (0,16), second beat (8,24), last beat (15,31).
- out_ready toggling 1,0,0,1 randomly during UNLOAD:
  - exactly 16 beats, no repeat or skip;
  - data stable while stalled.
- in_last asserted on beat 7 of 16:
  - frame_err=1 and stays high;
  - the FFT still starts after beat 16.
- Reset asserted mid-UNLOAD at beat 5:
  - all outputs 0 asynchronously, state IDLE;
  - a new frame then loads correctly from address 0.
